// File: rtl/rect_draw_sequencer.sv
// rect_draw_sequencer: per-frame erase/draw rectangle job issuer for the drawer.
// Holds NEW/SHADOW/OLD sprite tables and hands the drawer one job at a time.
module rect_draw_sequencer #(
    parameter int          NUM_OBJ   = 4,
    parameter logic [2:0]  BG_COLOUR = 3'b000,
    localparam int         IW        = $clog2(NUM_OBJ)
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_wr_en,
    input  logic [IW-1:0] i_wr_idx,
    input  logic [7:0]    i_wr_x,
    input  logic [6:0]    i_wr_y,
    input  logic [4:0]    i_wr_w,
    input  logic [4:0]    i_wr_h,
    input  logic [2:0]    i_wr_c,
    input  logic          i_wr_valid,
    input  logic          i_frame_start,
    output logic [7:0]    o_rd_x,
    output logic [6:0]    o_rd_y,
    output logic [4:0]    o_rd_w,
    output logic [4:0]    o_rd_h,
    output logic [2:0]    o_rd_c,
    output logic          o_rd_load_n,
    output logic          o_rd_draw,
    input  logic          i_rd_done,
    output logic          o_busy,
    output logic          o_frame_done
);
    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [4:0] w;
        logic [4:0] h;
        logic [2:0] c;
    } job_t;
    typedef struct packed {
        job_t j;
        logic v;
    } rec_t;
    typedef enum logic [2:0] {S_IDLE, S_ESEL, S_DSEL, S_LOAD, S_RUN, S_COMMIT} state_t;

    state_t          r_state, w_state_n;
    logic [IW-1:0]   r_idx, w_idx_n;
    logic            r_pass, w_pass_n;
    logic            w_ld;
    rec_t            r_new [NUM_OBJ];
    rec_t            r_shd [NUM_OBJ];
    rec_t            r_old [NUM_OBJ];
    job_t            r_job;
    rec_t            w_rec;
    job_t            w_job;
    logic            w_last;

    // Erase scan reads the last drawn copy, draw scan reads the frame snapshot
    assign w_rec  = (r_state == S_DSEL) ? r_shd[r_idx] : r_old[r_idx];
    assign w_job  = {w_rec.j.x, w_rec.j.y, w_rec.j.w, w_rec.j.h,
                     (r_state == S_DSEL) ? w_rec.j.c : BG_COLOUR};
    assign w_last = r_idx == IW'(NUM_OBJ - 1);

    always_comb begin
        w_state_n = r_state;
        w_idx_n   = r_idx;
        w_pass_n  = r_pass;
        w_ld      = 1'b0;
        case (r_state)
            S_IDLE: if (i_frame_start) begin
                w_state_n = S_ESEL;
                w_idx_n   = '0;
            end
            S_ESEL, S_DSEL: if (w_rec.v) begin
                w_state_n = S_LOAD;
                w_pass_n  = r_state == S_DSEL;
                w_ld      = 1'b1;
            end else if (w_last) begin
                w_state_n = (r_state == S_ESEL) ? S_DSEL : S_COMMIT;
                w_idx_n   = '0;
            end else begin
                w_idx_n = r_idx + 1'b1;
            end
            S_LOAD: w_state_n = S_RUN;
            // Terminal compare on the last record keeps idx from wrapping into a re-scan
            S_RUN: if (i_rd_done) begin
                if (w_last) begin
                    w_state_n = r_pass ? S_COMMIT : S_DSEL;
                    w_idx_n   = '0;
                end else begin
                    w_state_n = r_pass ? S_DSEL : S_ESEL;
                    w_idx_n   = r_idx + 1'b1;
                end
            end
            S_COMMIT: w_state_n = S_IDLE;
            default:  w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_pass  <= 1'b0;
            r_job   <= '0;
            for (int i = 0; i < NUM_OBJ; i++) begin
                r_new[i] <= '0;
                r_shd[i] <= '0;
                r_old[i] <= '0;
            end
        end else begin
            r_state <= w_state_n;
            r_idx   <= w_idx_n;
            r_pass  <= w_pass_n;
            if (w_ld)
                r_job <= w_job;
            if (i_wr_en)
                r_new[i_wr_idx] <= {i_wr_x, i_wr_y, i_wr_w, i_wr_h, i_wr_c, i_wr_valid};
            if (r_state == S_IDLE && i_frame_start)
                r_shd <= r_new;
            if (r_state == S_COMMIT)
                r_old <= r_shd;
        end
    end

    assign o_rd_x       = r_job.x;
    assign o_rd_y       = r_job.y;
    assign o_rd_w       = r_job.w;
    assign o_rd_h       = r_job.h;
    assign o_rd_c       = r_job.c;
    assign o_rd_load_n  = r_state != S_LOAD;
    assign o_rd_draw    = r_state == S_RUN && !i_rd_done;
    assign o_busy       = r_state != S_IDLE && r_state != S_COMMIT;
    assign o_frame_done = r_state == S_COMMIT;
endmodule
